// File: rtl/xif_issue_queue.sv
// CORE-V-XIF issue/commit tracking queue: buffers offloaded instructions and releases committed ones in order.
// Optional XIF_DUP_ID_CHECK_EN rejects issues whose id is already live in the queue.
module xif_issue_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_NUM_RS    = 3,
    parameter int XLEN        = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [31:0]                     issue_instr,
    input  logic [X_ID_WIDTH-1:0]           issue_id,
    input  logic [X_NUM_RS*XLEN-1:0]        issue_rs,
    input  logic [X_NUM_RS-1:0]             issue_rs_valid,
    input  logic                            dec_accept,
    output logic                            issue_accept,
    input  logic                            commit_valid,
    input  logic [X_ID_WIDTH-1:0]           commit_id,
    input  logic                            commit_kill,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_instr,
    output logic [X_ID_WIDTH-1:0]           out_id,
    output logic [X_NUM_RS*XLEN-1:0]        out_rs,
    output logic [$clog2(QUEUE_DEPTH):0]    count,
    output logic                            commit_err
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {EMPTY, PENDING, COMMITTED, KILLED} ent_state_t;

    ent_state_t                 st    [QUEUE_DEPTH];
    logic [31:0]                e_ins [QUEUE_DEPTH];
    logic [X_ID_WIDTH-1:0]      e_id  [QUEUE_DEPTH];
    logic [X_NUM_RS*XLEN-1:0]   e_rs  [QUEUE_DEPTH];
    logic [PTR_W-1:0]           head, tail;

    logic                       dup, issue_hs, issue_acc, same_cyc;
    logic                       match_found, pop, drop, head_adv, cerr_nxt;
    logic [PTR_W-1:0]           match_idx;
    logic                       unused_rs_valid;

    assign unused_rs_valid = ^issue_rs_valid;

    assign issue_ready  = (count != CNT_W'(QUEUE_DEPTH));
    assign issue_accept = dec_accept && !dup;
    assign issue_hs     = issue_valid && issue_ready;
    assign issue_acc    = issue_hs && issue_accept;

`ifdef XIF_DUP_ID_CHECK_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (st[i] != EMPTY && e_id[i] == issue_id) dup = 1'b1;
    end
`else
    assign dup = 1'b0;
`endif

    // Walk from the head so the oldest pending match wins when ids repeat.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            if (!match_found && commit_valid && st[head + PTR_W'(k)] == PENDING &&
                e_id[head + PTR_W'(k)] == commit_id) begin
                match_found = 1'b1;
                match_idx   = head + PTR_W'(k);
            end
        end
    end

    assign same_cyc = commit_valid && !match_found && issue_acc && (issue_id == commit_id);
    assign cerr_nxt = (commit_valid && !match_found && !same_cyc) || (issue_hs && dup);

    assign out_valid = (st[head] == COMMITTED);
    assign pop       = out_valid && out_ready;
    assign drop      = (st[head] == KILLED);
    assign head_adv  = pop || drop;

    assign out_instr = (st[head] != EMPTY) ? e_ins[head] : '0;
    assign out_id    = (st[head] != EMPTY) ? e_id[head]  : '0;
    assign out_rs    = (st[head] != EMPTY) ? e_rs[head]  : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                st[i]    <= EMPTY;
                e_ins[i] <= '0;
                e_id[i]  <= '0;
                e_rs[i]  <= '0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            commit_err <= 1'b0;
        end else begin
            commit_err <= cerr_nxt;
            // Match slot is PENDING, head slot is resolved and tail slot is EMPTY, so these never collide.
            if (match_found)
                st[match_idx] <= commit_kill ? KILLED : COMMITTED;
            if (head_adv) begin
                st[head] <= EMPTY;
                head     <= head + 1'b1;
            end
            if (issue_acc) begin
                st[tail]    <= same_cyc ? (commit_kill ? KILLED : COMMITTED) : PENDING;
                e_ins[tail] <= issue_instr;
                e_id[tail]  <= issue_id;
                e_rs[tail]  <= issue_rs;
                tail        <= tail + 1'b1;
            end
            case ({issue_acc, head_adv})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
